// File: rtl/distributor.sv
// distributor: steers one valid/ready stream of packed beats to one of two buffered branches by a select bit
module distributor_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         rdy,
  output logic         valid,
  output logic [W-1:0] q
);
  logic [1:0]   count;
  logic [W-1:0] h, s;
  logic         pop;
  assign rdy   = count != 2'd2;
  assign valid = count != 2'd0;
  assign q     = h;
  assign pop   = valid && ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      h     <= '0;
      s     <= '0;
    end else if (count == 2'd0) begin
      if (push) begin
        h     <= d;
        count <= 2'd1;
      end
    end else if (count == 2'd1) begin
      if (push && pop) h <= d;
      else if (push) begin
        s     <= d;
        count <= 2'd2;
      end else if (pop) count <= 2'd0;
    end else if (pop) begin
      h     <= s;
      count <= 2'd1;
    end
  end
endmodule

module distributor #(
  parameter int WIDTH0 = 32,
  parameter int WIDTH1 = 32
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iValid_AS,
  output logic                     oReady_AS,
  input  logic                     iSelect_AS,
  input  logic [WIDTH1+WIDTH0-1:0] iData_AS,
  output logic                     oValid_BM0,
  input  logic                     iReady_BM0,
  output logic [WIDTH0-1:0]        oData_BM0,
  output logic                     oValid_BM1,
  input  logic                     iReady_BM1,
  output logic [WIDTH1-1:0]        oData_BM1
);
  logic rdy0, rdy1;
  assign oReady_AS = iSelect_AS ? rdy1 : rdy0;
  distributor_buf #(.W(WIDTH0)) b0 (
    .clk(iCLK), .rst(iRST),
    .push(iValid_AS && oReady_AS && !iSelect_AS),
    .d(iData_AS[WIDTH0-1:0]),
    .ready(iReady_BM0), .rdy(rdy0), .valid(oValid_BM0), .q(oData_BM0)
  );
  distributor_buf #(.W(WIDTH1)) b1 (
    .clk(iCLK), .rst(iRST),
    .push(iValid_AS && oReady_AS && iSelect_AS),
    .d(iData_AS[WIDTH1+WIDTH0-1:WIDTH0]),
    .ready(iReady_BM1), .rdy(rdy1), .valid(oValid_BM1), .q(oData_BM1)
  );
endmodule

// File: tb/tb_distributor.sv
// tb_distributor: directed self-checking bench for distributor with 8-bit branches
module tb_distributor;
  logic        clk = 0, rst = 1;
  logic        valid = 0, sel = 0, ready0 = 1, ready1 = 1;
  logic [15:0] data = '0;
  logic        ready_as, valid0, valid1;
  logic [7:0]  data0, data1;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  distributor #(.WIDTH0(8), .WIDTH1(8)) dut (
    .iCLK(clk), .iRST(rst),
    .iValid_AS(valid), .oReady_AS(ready_as), .iSelect_AS(sel), .iData_AS(data),
    .oValid_BM0(valid0), .iReady_BM0(ready0), .oData_BM0(data0),
    .oValid_BM1(valid1), .iReady_BM1(ready1), .oData_BM1(data1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic s, input logic [15:0] d);
    valid = v;
    sel   = s;
    data  = d;
    #1;
  endtask
  initial begin
    drive(1, 0, 16'hA55A);
    tick;
    tick;
    check("rst_v0", valid0, 0);
    check("rst_v1", valid1, 0);
    check("rst_d0", data0, 0);
    check("rst_d1", data1, 0);
    check("rst_rdy", ready_as, 1);
    rst = 0;
    drive(0, 0, 16'h0);
    tick;
    check("rst_nostore_v0", valid0, 0);
    check("rst_nostore_v1", valid1, 0);
    drive(1, 0, 16'h1234);
    tick;
    drive(0, 0, 16'h0);
    check("route_v0", valid0, 1);
    check("route_d0", data0, 8'h34);
    check("route_v1_idle", valid1, 0);
    drive(1, 1, 16'h5678);
    tick;
    drive(0, 0, 16'h0);
    check("route_v1", valid1, 1);
    check("route_d1", data1, 8'h56);
    check("route_v0_once", valid0, 0);
    tick;
    check("route_v1_once", valid1, 0);
    ready0 = 0;
    drive(1, 0, 16'h0001);
    tick;
    drive(1, 0, 16'h0002);
    check("fill_rdy1", ready_as, 1);
    tick;
    drive(1, 0, 16'h0003);
    check("fill_full", ready_as, 0);
    check("fill_v0", valid0, 1);
    check("fill_d0", data0, 8'h01);
    tick;
    check("fill_hold_rdy", ready_as, 0);
    check("fill_hold_d0", data0, 8'h01);
    drive(1, 1, 16'hC300);
    check("indep_rdy", ready_as, 1);
    tick;
    drive(0, 0, 16'h0);
    check("indep_v1", valid1, 1);
    check("indep_d1", data1, 8'hC3);
    check("indep_v0", valid0, 1);
    check("indep_d0", data0, 8'h01);
    tick;
    check("indep_v1_once", valid1, 0);
    check("indep_d0_stable", data0, 8'h01);
    drive(1, 0, 16'h0003);
    ready0 = 1;
    #1;
    check("drain_rdy_full", ready_as, 0);
    tick;
    check("drain_d02", data0, 8'h02);
    check("drain_rdy_back", ready_as, 1);
    tick;
    drive(0, 0, 16'h0);
    check("drain_v03", valid0, 1);
    check("drain_d03", data0, 8'h03);
    tick;
    check("drain_empty", valid0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 16'(i));
      check("tput_rdy", ready_as, 1);
      tick;
      check("tput_v0", valid0, 1);
      check("tput_d0", data0, 32'(i));
    end
    drive(0, 0, 16'h0);
    tick;
    check("tput_end", valid0, 0);
    ready0 = 0;
    ready1 = 0;
    drive(1, 0, 16'h00AA);
    tick;
    drive(1, 0, 16'h00BB);
    tick;
    drive(1, 1, 16'hCC00);
    tick;
    drive(1, 1, 16'hDD00);
    tick;
    drive(0, 1, 16'h0);
    check("mid_full1", ready_as, 0);
    sel = 0;
    #1;
    check("mid_full0", ready_as, 0);
    check("mid_d0", data0, 8'hAA);
    check("mid_d1", data1, 8'hCC);
    rst = 1;
    tick;
    rst = 0;
    check("mid_v0", valid0, 0);
    check("mid_v1", valid1, 0);
    check("mid_d0_clr", data0, 0);
    check("mid_d1_clr", data1, 0);
    check("mid_rdy", ready_as, 1);
    tick;
    check("mid_v0_stay", valid0, 0);
    check("mid_v1_stay", valid1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/distributor.md
Name: distributor

Overview:
- Inverse of the two-input collector stage: takes one valid/ready stream that carries packed data and a select bit, and steers each beat to one of two output streams.
- sel=0 → branch 0 gets the low WIDTH0 bits; sel=1 → branch 1 gets the high WIDTH1 bits.
- Each branch has its own 2-entry elastic buffer:
  - full throughput per branch;
  - registered output valid/data;
  - a stall on one branch does not block beats addressed to the other branch.

Parameters:
- WIDTH0, 32, data width of branch 0 (low field of the input word)
- WIDTH1, 32, data width of branch 1 (high field of the input word)

Ports:
- iCLK  input  1  clock; all state updates on the rising edge
- iRST  input  1  reset, synchronous, active-high
- iValid_AS  input  1  input beat valid
- oReady_AS  output  1  input beat accepted when high together with iValid_AS
- iSelect_AS  input  1  destination branch of the current beat
- iData_AS  input  WIDTH1+WIDTH0  packed {data1, data0}
- oValid_BM0  output  1  branch 0 valid
- iReady_BM0  input  1  branch 0 ready
- oData_BM0  output  WIDTH0  branch 0 data
- oValid_BM1  output  1  branch 1 valid
- iReady_BM1  input  1  branch 1 ready
- oData_BM1  output  WIDTH1  branch 1 data

Behaviour:
- Single clock iCLK; reset iRST is synchronous and active-high.
- Per-branch state (n = 0, 1):
  - count_n in {0, 1, 2};
  - head register h_n and skid register s_n, each WIDTHn bits.
- Reset (iRST=1 at a clock edge):
  - count_n ← 0, h_n ← 0, s_n ← 0;
  - so oValid_BM0 = oValid_BM1 = 0, oData_BM0 = oData_BM1 = 0, and both branch readies are 1.
  - Reset mid-operation discards all buffered beats.
  - Reset has priority over any simultaneous handshake.
- Branch ready: rdy_n = (count_n != 2). rdy_n is a function of registered state only.
- Input ready: oReady_AS = iSelect_AS ? rdy_1 : rdy_0.
  - Combinational from iSelect_AS and state only; independent of iValid_AS.
  - The upstream must hold iSelect_AS and iData_AS stable while iValid_AS=1 and oReady_AS=0.
- Push and pop:
  - push_n = iValid_AS && oReady_AS && (iSelect_AS == n).
  - At most one branch pushes per cycle.
  - Branch 0 takes iData_AS[WIDTH0-1:0]; branch 1 takes iData_AS[WIDTH1+WIDTH0-1:WIDTH0].
  - pop_n = oValid_BMn && iReady_BMn.
  - Both branches may pop in the same cycle.
- Outputs: oValid_BMn = (count_n != 0); oData_BMn = h_n. Both driven directly from registers.
- Per-branch transitions (on iCLK edge, iRST=0):
  - count 0, push → h ← d, count 1.
  - count 1, push only → s ← d, count 2.
  - count 1, pop only → count 0.
  - count 1, push & pop → h ← d, count 1.
  - count 2, pop → h ← s, count 1 (push impossible, since rdy=0).
  - Otherwise, hold.
- Latency: a beat accepted at edge k appears on oValid_BMn/oData_BMn after edge k (1 cycle).
- Ordering: beats are in-order within each branch. No ordering is implied between branches.
- Throughput: one beat per cycle sustained to either branch while that branch's downstream ready stays high.
- h_n and s_n keep their last value when invalid; downstream must ignore data while valid=0.
- Output data and valid do not change while oValid_BMn=1 and iReady_BMn=0.

Test Plan:
- Reset: hold iRST=1 for 2 cycles with iValid_AS=1, iData_AS=16'hA55A (WIDTH0=WIDTH1=8).
  → Both oValid_BM=0, both oData=0, oReady_AS=1, and no beat is stored after iRST falls.
- Routing: send 16'h12_34 with sel=0, then 16'h56_78 with sel=1, both downstream ready=1.
  → oData_BM0=8'h34 valid one cycle after the first accept; oData_BM1=8'h56 one cycle after the second; each valid for exactly one cycle.
- Back-pressure fill: iReady_BM0=0, stream sel=0 beats 8'h01, 8'h02, 8'h03.
  → First two are accepted and oReady_AS drops to 0 with 8'h03 held.
  → Raise iReady_BM0: outputs 01, 02, 03 in order; oReady_AS returns to 1 the cycle after the first pop.
- Independence: branch 0 full (iReady_BM0=0), then present a sel=1 beat 8'hC3.
  → oReady_AS=1, and 8'hC3 appears on branch 1 next cycle while branch 0 holds 8'h01 valid and stable.
- Full throughput with push & pop at count 1: 16 back-to-back sel=0 beats 0..15 with iReady_BM0=1.
  → oValid_BM0 high for 16 consecutive cycles with data 0..15; oReady_AS never low.
- Mid-operation reset: both branches holding 2 beats, assert iRST for 1 cycle.
  → Both valids go 0 on the next cycle and stay 0 until new beats are pushed.
